// File: rtl/alu_writeback_pkg.sv
// alu_writeback_pkg: shared definitions for the ALU writeback stage.
//   - ALU opcode constants and the opcode-to-commit-class decode
//   - commit class enum and capture FSM state enum
//   - NZCV bit positions within the 4-bit flag word {N,Z,C,V}
package alu_writeback_pkg;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_MVN    = 4'b0110;
    localparam logic [3:0] OP_MOV    = 4'b0111;
    localparam logic [3:0] OP_CMP    = 4'b1011;
    localparam logic [3:0] OP_MEM_LO = 4'b1100;
    localparam logic [3:0] OP_MEM_HI = 4'b1111;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        CLS_REG_FLAG,
        CLS_REG_ONLY,
        CLS_FLAG_ONLY,
        CLS_NONE
    } commit_cls_e;

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } wb_state_e;

    function automatic commit_cls_e classify(input logic [3:0] op);
        commit_cls_e cls;
        if (op == OP_CMP)
            cls = CLS_FLAG_ONLY;
        else if (op >= OP_MEM_LO)
            cls = CLS_NONE;
        else if (op == OP_MVN || op == OP_MOV)
            cls = CLS_REG_ONLY;
        else
            cls = CLS_REG_FLAG;
        return cls;
    endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// alu_writeback_if: bus between the ALU, the load unit and the writeback stage.
//   ALU result handshake : in_valid/in_ready, in_opcode, in_s, in_rd, in_result, in_flag
//   load write port      : ld_valid, ld_rd, ld_data (always accepted)
//   operand read ports   : rd_addr_a/b -> rd_data_a/b
//   status               : flag_out (NZCV), retire_cnt
// Modports: slave = writeback stage, master = ALU/load side driving it.
interface alu_writeback_if #(
    parameter int unsigned DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_opcode;
    logic          in_s;
    logic [3:0]    in_rd;
    logic [DW-1:0] in_result;
    logic [3:0]    in_flag;
    logic          ld_valid;
    logic [3:0]    ld_rd;
    logic [DW-1:0] ld_data;
    logic [3:0]    rd_addr_a;
    logic [3:0]    rd_addr_b;
    logic [DW-1:0] rd_data_a;
    logic [DW-1:0] rd_data_b;
    logic [3:0]    flag_out;
    logic [31:0]   retire_cnt;

    modport slave (
        input  in_valid, in_opcode, in_s, in_rd, in_result, in_flag,
        input  ld_valid, ld_rd, ld_data,
        input  rd_addr_a, rd_addr_b,
        output in_ready, rd_data_a, rd_data_b, flag_out, retire_cnt
    );

    modport master (
        output in_valid, in_opcode, in_s, in_rd, in_result, in_flag,
        output ld_valid, ld_rd, ld_data,
        output rd_addr_a, rd_addr_b,
        input  in_ready, rd_data_a, rd_data_b, flag_out, retire_cnt
    );
endinterface

// File: rtl/alu_writeback_regfile.sv
// wb_regfile: NREGS x DW register file, one write port, two combinational
// read ports. Synchronous active-high reset clears every entry.
// Optional macro WB_FORWARD_EN: reads of the index being written this cycle
// return the write data instead of the stored value.
//   clk, reset         : clock / synchronous reset
//   we, waddr, wdata   : write port
//   raddr_a/b, rdata_a/b : read ports
module wb_regfile #(
    parameter int unsigned NREGS = 16,
    parameter int unsigned DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(NREGS)-1:0] raddr_a,
    input  logic [$clog2(NREGS)-1:0] raddr_b,
    output logic [DW-1:0]            rdata_a,
    output logic [DW-1:0]            rdata_b
);

    logic [DW-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++)
                mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef WB_FORWARD_EN
    always_comb begin
        rdata_a = mem[raddr_a];
        rdata_b = mem[raddr_b];
        if (we && waddr == raddr_a)
            rdata_a = wdata;
        if (we && waddr == raddr_b)
            rdata_b = wdata;
    end
`else
    always_comb begin
        rdata_a = mem[raddr_a];
        rdata_b = mem[raddr_b];
    end
`endif

endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: writeback stage downstream of the ALU.
// Captures one ALU result per cycle into a single-entry register and commits
// it to the register file / NZCV flag register. A load write shares the
// register-file write port and wins; a register-writing entry then stalls.
// Optional macro WB_FORWARD_EN: bypass pending writes onto the read ports
// and flag_out.
//   clk, reset : clock, synchronous active-high reset
//   wb         : alu_writeback_if.slave (handshake, load port, read ports,
//                flag_out, retire_cnt)
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int unsigned NREGS = 16,
    parameter int unsigned DW    = 32
) (
    input  logic           clk,
    input  logic           reset,
    alu_writeback_if.slave wb
);

    wb_state_e     state, state_nxt;
    logic          cap_valid;
    logic [3:0]    cap_opcode;
    logic          cap_s;
    logic [3:0]    cap_rd;
    logic [DW-1:0] cap_result;
    logic [3:0]    cap_flag;
    logic [3:0]    flag_q;
    logic [31:0]   retire_q;

    commit_cls_e   cls;
    logic          writes_reg;
    logic          writes_flag;
    logic          commit;
    logic          accept;
    logic          rf_we;
    logic [3:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;

    assign cap_valid = (state == ST_FULL);

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_EMPTY;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_EMPTY: if (accept) state_nxt = ST_FULL;
            ST_FULL:  if (commit && !wb.in_valid) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // Output / commit logic. A stall only arises when the entry needs the
    // shared write port; CMP and discarded entries commit next to a load.
    always_comb begin
        cls         = classify(cap_opcode);
        writes_reg  = (cls == CLS_REG_FLAG) || (cls == CLS_REG_ONLY);
        writes_flag = (cls == CLS_FLAG_ONLY) || (cls == CLS_REG_FLAG && cap_s);
        commit      = cap_valid && !(writes_reg && wb.ld_valid);
        wb.in_ready = !cap_valid || commit;
        accept      = wb.in_valid && wb.in_ready;
        rf_we       = wb.ld_valid || (commit && writes_reg);
        rf_waddr    = wb.ld_valid ? wb.ld_rd : cap_rd;
        rf_wdata    = wb.ld_valid ? wb.ld_data : cap_result;
    end

    // Capture register payload
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_opcode <= '0;
            cap_s      <= 1'b0;
            cap_rd     <= '0;
            cap_result <= '0;
            cap_flag   <= '0;
        end else if (accept) begin
            cap_opcode <= wb.in_opcode;
            cap_s      <= wb.in_s;
            cap_rd     <= wb.in_rd;
            cap_result <= wb.in_result;
            cap_flag   <= wb.in_flag;
        end
    end

    // Flag register and retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_q   <= '0;
            retire_q <= '0;
        end else if (commit) begin
            retire_q <= retire_q + 32'd1;
            if (writes_flag)
                flag_q <= cap_flag;
        end
    end

    assign wb.retire_cnt = retire_q;

`ifdef WB_FORWARD_EN
    assign wb.flag_out = (commit && writes_flag) ? cap_flag : flag_q;
`else
    assign wb.flag_out = flag_q;
`endif

    wb_regfile #(
        .NREGS(NREGS),
        .DW   (DW)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata),
        .raddr_a(wb.rd_addr_a),
        .raddr_b(wb.rd_addr_b),
        .rdata_a(wb.rd_data_a),
        .rdata_b(wb.rd_data_b)
    );

endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed test of alu_writeback against an
// instruction-level model of the writeback rules, checked every negedge,
// plus hand-computed literal expectations at key points.
module tb_alu_writeback;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic armed;

    alu_writeback_if #(.DW(32)) bus ();

    alu_writeback #(.NREGS(16), .DW(32)) dut (
        .clk  (clk),
        .reset(reset),
        .wb   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction-level model: one pending entry, architectural regs/flags/count.
    logic        m_valid;
    logic [3:0]  m_op;
    logic        m_s;
    logic [3:0]  m_rd;
    logic [31:0] m_res;
    logic [3:0]  m_flag;
    logic [31:0] m_regs [16];
    logic [3:0]  m_flags;
    logic [31:0] m_cnt;

    always @(negedge clk) begin
        logic        wr_reg, wr_flag, commit, exp_ready;
        logic [31:0] ea, eb;
        logic [3:0]  ef;
        wr_reg    = m_valid && (m_op <= 4'd10);
        wr_flag   = m_valid && ((m_op == 4'd11) ||
                    (m_s && m_op <= 4'd10 && m_op != 4'd6 && m_op != 4'd7));
        commit    = m_valid && !(wr_reg && bus.ld_valid);
        exp_ready = !m_valid || commit;
        ea = m_regs[bus.rd_addr_a];
        eb = m_regs[bus.rd_addr_b];
        ef = m_flags;
`ifdef WB_FORWARD_EN
        if (bus.ld_valid && bus.ld_rd == bus.rd_addr_a) ea = bus.ld_data;
        else if (commit && wr_reg && m_rd == bus.rd_addr_a) ea = m_res;
        if (bus.ld_valid && bus.ld_rd == bus.rd_addr_b) eb = bus.ld_data;
        else if (commit && wr_reg && m_rd == bus.rd_addr_b) eb = m_res;
        if (commit && wr_flag) ef = m_flag;
`endif
        if (armed) begin
            check("model_in_ready",   64'(bus.in_ready),   64'(exp_ready));
            check("model_rd_data_a",  64'(bus.rd_data_a),  64'(ea));
            check("model_rd_data_b",  64'(bus.rd_data_b),  64'(eb));
            check("model_flag_out",   64'(bus.flag_out),   64'(ef));
            check("model_retire_cnt", 64'(bus.retire_cnt), 64'(m_cnt));
        end
        // advance the model to the state after the coming posedge
        if (reset) begin
            m_valid = 1'b0;
            for (int i = 0; i < 16; i++) m_regs[i] = '0;
            m_flags = '0;
            m_cnt   = '0;
            armed   = 1'b1;
        end else begin
            if (bus.ld_valid) m_regs[bus.ld_rd] = bus.ld_data;
            if (commit) begin
                if (wr_reg)  m_regs[m_rd] = m_res;
                if (wr_flag) m_flags = m_flag;
                m_cnt   = m_cnt + 1;
                m_valid = 1'b0;
            end
            if (bus.in_valid && exp_ready) begin
                m_valid = 1'b1;
                m_op    = bus.in_opcode;
                m_s     = bus.in_s;
                m_rd    = bus.in_rd;
                m_res   = bus.in_result;
                m_flag  = bus.in_flag;
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic s, input logic [3:0] rd,
                        input logic [31:0] res, input logic [3:0] fl);
        int n;
        bus.in_valid  = 1'b1;
        bus.in_opcode = op;
        bus.in_s      = s;
        bus.in_rd     = rd;
        bus.in_result = res;
        bus.in_flag   = fl;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("send_accepted", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        armed  = 1'b0;
        m_valid = 1'b0;
        m_op = '0; m_s = 1'b0; m_rd = '0; m_res = '0; m_flag = '0;
        m_flags = '0; m_cnt = '0;
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_s = 1'b0; bus.in_rd = '0;
        bus.in_result = '0; bus.in_flag = '0;
        bus.ld_valid = 1'b0; bus.ld_rd = '0; bus.ld_data = '0;
        bus.rd_addr_a = '0; bus.rd_addr_b = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        @(negedge clk);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_flag", 64'(bus.flag_out), 64'd0);
        check("reset_cnt", 64'(bus.retire_cnt), 64'd0);
        check("reset_reg0", 64'(bus.rd_data_a), 64'd0);
        @(posedge clk); #1;

        // ADD, s=1
        send(4'b0000, 1'b1, 4'd3, 32'h5, 4'b0000);
        @(posedge clk); #1 bus.rd_addr_a = 4'd3;
        @(negedge clk);
        check("add_reg3", 64'(bus.rd_data_a), 64'h5);
        check("add_flag", 64'(bus.flag_out), 64'h0);
        check("add_cnt", 64'(bus.retire_cnt), 64'd1);

        // CMP
        @(posedge clk); #1;
        send(4'b1011, 1'b0, 4'd7, 32'h1234, 4'b0100);
        @(posedge clk); #1 bus.rd_addr_a = 4'd7;
        @(negedge clk);
        check("cmp_flag", 64'(bus.flag_out), 64'h4);
        check("cmp_reg7", 64'(bus.rd_data_a), 64'h0);
        check("cmp_cnt", 64'(bus.retire_cnt), 64'd2);

        // MOV ignores s
        @(posedge clk); #1;
        send(4'b0111, 1'b1, 4'd2, 32'hDEAD_BEEF, 4'b1000);
        @(posedge clk); #1 bus.rd_addr_a = 4'd2;
        @(negedge clk);
        check("mov_reg2", 64'(bus.rd_data_a), 64'hDEAD_BEEF);
        check("mov_flag", 64'(bus.flag_out), 64'h4);
        check("mov_cnt", 64'(bus.retire_cnt), 64'd3);

        // Discarded opcode commits alongside a load
        @(posedge clk); #1;
        send(4'b1100, 1'b1, 4'd9, 32'hFF, 4'b1111);
        bus.ld_valid = 1'b1; bus.ld_rd = 4'd9; bus.ld_data = 32'h99;
        bus.rd_addr_b = 4'd9;
        @(negedge clk);
        check("mem_no_conflict_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1 bus.ld_valid = 1'b0;
        @(negedge clk);
        check("mem_reg9_load", 64'(bus.rd_data_b), 64'h99);
        check("mem_flag", 64'(bus.flag_out), 64'h4);
        check("mem_cnt", 64'(bus.retire_cnt), 64'd4);

        // Load conflict for 2 cycles
        @(posedge clk); #1;
        send(4'b0000, 1'b0, 4'd4, 32'h9, 4'b0000);
        bus.ld_valid = 1'b1; bus.ld_rd = 4'd4; bus.ld_data = 32'h1;
        bus.rd_addr_a = 4'd4;
        @(negedge clk);
        check("conflict_ready_c1", 64'(bus.in_ready), 64'd0);
`ifdef WB_FORWARD_EN
        check("conflict_reg4_c1", 64'(bus.rd_data_a), 64'h1);
`else
        check("conflict_reg4_c1", 64'(bus.rd_data_a), 64'h0);
`endif
        @(posedge clk); #1;
        @(negedge clk);
        check("conflict_ready_c2", 64'(bus.in_ready), 64'd0);
        check("conflict_reg4_c2", 64'(bus.rd_data_a), 64'h1);
        @(posedge clk); #1 bus.ld_valid = 1'b0;
        @(negedge clk);
        check("conflict_retry_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("conflict_reg4_final", 64'(bus.rd_data_a), 64'h9);
        check("conflict_cnt", 64'(bus.retire_cnt), 64'd5);

        // Back-to-back ADDs from a fresh reset
        @(posedge clk);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_opcode = 4'b0000;
            bus.in_s      = 1'b0;
            bus.in_rd     = 4'(8 + i);
            bus.in_result = 32'h100 + 32'(i);
            bus.in_flag   = 4'b0000;
            bus.rd_addr_a = 4'(7 + i);
            @(negedge clk);
            check("b2b_ready", 64'(bus.in_ready), 64'd1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.rd_addr_a = 4'd15;
        @(negedge clk);
        check("b2b_cnt_before_last", 64'(bus.retire_cnt), 64'd7);
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b_cnt", 64'(bus.retire_cnt), 64'd8);
        check("b2b_reg15", 64'(bus.rd_data_a), 64'h107);

        // Reset mid-stall
        @(posedge clk); #1;
        send(4'b0000, 1'b0, 4'd5, 32'h55, 4'b0000);
        bus.ld_valid = 1'b1; bus.ld_rd = 4'd6; bus.ld_data = 32'h66;
        @(negedge clk);
        check("rst_stall_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; bus.ld_valid = 1'b0;
        bus.rd_addr_a = 4'd5; bus.rd_addr_b = 4'd6;
        @(negedge clk);
        check("rst_stall_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_stall_cnt", 64'(bus.retire_cnt), 64'd0);
        check("rst_stall_reg5", 64'(bus.rd_data_a), 64'd0);
        check("rst_stall_reg6", 64'(bus.rd_data_b), 64'd0);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1 bus.rd_addr_a = 4'(i);
            @(negedge clk);
            check("rst_all_zero", 64'(bus.rd_data_a), 64'd0);
        end
        check("rst_stall_cnt_after", 64'(bus.retire_cnt), 64'd0);

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
